// File: rtl/rsa_pkg.sv
// Shared width, FSM encoding, latency constant and the single interleaved
// modular-multiply step used by the RSA decryption core.
package rsa_pkg;

    localparam int W   = 8;
    localparam int IW  = $clog2(W);
    localparam int LAT = 2 + 2 * W * (W + 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CHECK = 3'd1,
        ST_SQR   = 3'd2,
        ST_MUL   = 3'd3,
        ST_FIN   = 3'd4
    } state_e;

    // One shift-add iteration: acc' = (2*acc + (b ? a : 0)) mod n, with a, acc < n
    function automatic logic [W-1:0] mod_step(input logic [W-1:0] acc,
                                              input logic [W-1:0] a,
                                              input logic [W-1:0] n,
                                              input logic         bit_b);
        logic [W:0] t;
        logic [W:0] u;
        t = {acc, 1'b0};
        if (t >= {1'b0, n}) t = t - {1'b0, n};
        else                t = t;
        u = t + (bit_b ? {1'b0, a} : {(W+1){1'b0}});
        if (u >= {1'b0, n}) u = u - {1'b0, n};
        else                u = u;
        return u[W-1:0];
    endfunction

endpackage

// File: rtl/rsa_decrypt_core_if.sv
// Request/response bundle of the decryption core: operands and start in,
// plaintext with busy/done/err status out.
interface rsa_decrypt_core_if;

    logic                   start;
    logic [rsa_pkg::W-1:0]  C;
    logic [rsa_pkg::W-1:0]  d;
    logic [rsa_pkg::W-1:0]  N;
    logic [rsa_pkg::W-1:0]  M;
    logic                   busy;
    logic                   done;
    logic                   err;

    modport master (output start, C, d, N, input  M, busy, done, err);
    modport slave  (input  start, C, d, N, output M, busy, done, err);

endinterface

// File: rtl/mod_mul_seq.sv
// Iterative interleaved modular multiplier P = A*B mod N, MSB of B first.
// The start edge already consumes B[W-1], so done pulses W cycles after start.
module mod_mul_seq
    import rsa_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    input  logic [W-1:0] N,
    output logic [W-1:0] P,
    output logic         done
);

    logic [W-1:0]  r_a;
    logic [W-1:0]  r_b;
    logic [W-1:0]  r_n;
    logic [W-1:0]  r_acc;
    logic [IW-1:0] r_cnt;
    logic          r_run;
    logic          r_done;

    // Operand capture and one reduction step per cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_a    <= {W{1'b0}};
            r_b    <= {W{1'b0}};
            r_n    <= {W{1'b0}};
            r_acc  <= {W{1'b0}};
            r_cnt  <= {IW{1'b0}};
            r_run  <= 1'b0;
            r_done <= 1'b0;
        end else if (start) begin
            r_a    <= A;
            r_b    <= B;
            r_n    <= N;
            r_acc  <= mod_step({W{1'b0}}, A, N, B[W-1]);
            r_cnt  <= IW'(W - 2);
            r_run  <= 1'b1;
            r_done <= 1'b0;
        end else if (r_run) begin
            r_acc  <= mod_step(r_acc, r_a, r_n, r_b[r_cnt]);
            r_cnt  <= r_cnt - IW'(1);
            r_run  <= (r_cnt != {IW{1'b0}});
            r_done <= (r_cnt == {IW{1'b0}});
        end else begin
            r_done <= 1'b0;
        end
    end

    assign P    = r_acc;
    assign done = r_done;

endmodule

// File: rtl/rsa_decrypt_core.sv
// RSA decryption M = C^d mod N by left-to-right square-and-multiply; the
// multiply is always performed so latency does not depend on d.
module rsa_decrypt_core
    import rsa_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    rsa_decrypt_core_if.slave  bus
);

    state_e        r_state;
    state_e        w_state_next;
    logic [W-1:0]  r_c;
    logic [W-1:0]  r_d;
    logic [W-1:0]  r_n;
    logic [W-1:0]  r_result;
    logic [W-1:0]  r_t;
    logic [IW-1:0] r_idx;
    logic          r_bad;
    logic          r_issue;
    logic [W-1:0]  r_m;
    logic          r_busy;
    logic          r_done;
    logic          r_err;
    logic          w_bad;
    logic [W-1:0]  w_mul_a;
    logic [W-1:0]  w_mul_b;
    logic [W-1:0]  w_mul_p;
    logic          w_mul_done;

    assign w_bad = (r_n < 8'd2) || (r_c >= r_n);

    mod_mul_seq u_mul (
        .clk   (clk),
        .reset (reset),
        .start (r_issue),
        .A     (w_mul_a),
        .B     (w_mul_b),
        .N     (r_n),
        .P     (w_mul_p),
        .done  (w_mul_done)
    );

    // Multiplier operand select: square in SQR, multiply by C in MUL
    always_comb begin
        w_mul_a = r_result;
        w_mul_b = r_result;
        if (r_state == ST_MUL) begin
            w_mul_a = r_t;
            w_mul_b = r_c;
        end else begin
            w_mul_a = r_result;
            w_mul_b = r_result;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (bus.start) w_state_next = ST_CHECK;
                      else           w_state_next = ST_IDLE;
            ST_CHECK: if (w_bad)     w_state_next = ST_FIN;
                      else           w_state_next = ST_SQR;
            ST_SQR:   if (w_mul_done) w_state_next = ST_MUL;
                      else            w_state_next = ST_SQR;
            ST_MUL: begin
                if (w_mul_done) begin
                    if (r_idx == {IW{1'b0}}) w_state_next = ST_FIN;
                    else                     w_state_next = ST_SQR;
                end else begin
                    w_state_next = ST_MUL;
                end
            end
            ST_FIN:   w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_next;
    end

    // Datapath, multiplier issue and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_c      <= {W{1'b0}};
            r_d      <= {W{1'b0}};
            r_n      <= {W{1'b0}};
            r_result <= {W{1'b0}};
            r_t      <= {W{1'b0}};
            r_idx    <= {IW{1'b0}};
            r_bad    <= 1'b0;
            r_issue  <= 1'b0;
            r_m      <= {W{1'b0}};
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_done  <= 1'b0;
            // Every entry into SQR or MUL launches exactly one product
            r_issue <= (w_state_next != r_state) &&
                       ((w_state_next == ST_SQR) || (w_state_next == ST_MUL));
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_c    <= bus.C;
                        r_d    <= bus.d;
                        r_n    <= bus.N;
                        r_err  <= 1'b0;
                        r_bad  <= 1'b0;
                        r_busy <= 1'b1;
                    end
                end
                ST_CHECK: begin
                    if (w_bad) begin
                        r_bad <= 1'b1;
                    end else begin
                        r_result <= {{(W-1){1'b0}}, 1'b1};
                        r_idx    <= IW'(W - 1);
                    end
                end
                ST_SQR: begin
                    if (w_mul_done) r_t <= w_mul_p;
                end
                ST_MUL: begin
                    if (w_mul_done) begin
                        r_result <= r_d[r_idx] ? w_mul_p : r_t;
                        if (r_idx != {IW{1'b0}}) r_idx <= r_idx - IW'(1);
                    end
                end
                ST_FIN: begin
                    r_done <= 1'b1;
                    r_busy <= 1'b0;
                    r_err  <= r_bad;
                    r_m    <= r_bad ? {W{1'b0}} : r_result;
                end
                default: begin
                    r_busy <= 1'b0;
                end
            endcase
        end
    end

    assign bus.M    = r_m;
    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.err  = r_err;

endmodule

// File: tb/tb_rsa_decrypt_core.sv
// Scoreboard bench for rsa_decrypt_core: expected plaintext from repeated
// modular multiplication, checked by a monitor whenever done pulses.
module tb_rsa_decrypt_core;

    localparam int LAT_OK  = 2 + 2 * 8 * 9;
    localparam int LAT_BAD = 2;

    typedef struct {
        int m;
        int err;
        int lat;
        int start_cyc;
    } exp_t;

    logic clk;
    logic reset;
    int   cyc;
    int   n_vec;
    int   n_err;
    int   busy_bad;
    bit   prev_done;
    exp_t sb[$];

    rsa_decrypt_core_if bus();

    rsa_decrypt_core dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: C multiplied into 1 d times, each step reduced mod N
    task automatic model(input int c, input int dd, input int n, output exp_t e);
        int r;
        if (n < 2 || c >= n) begin
            e.m = 0; e.err = 1; e.lat = LAT_BAD;
        end else begin
            r = 1;
            for (int i = 0; i < dd; i++) r = (r * c) % n;
            e.m = r; e.err = 0; e.lat = LAT_OK;
        end
    endtask

    task automatic launch(input int c, input int dd, input int n);
        exp_t e;
        model(c, dd, n, e);
        @(negedge clk);
        bus.C = 8'(c); bus.d = 8'(dd); bus.N = 8'(n); bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start   = 1'b0;
        e.start_cyc = cyc;
        sb.push_back(e);
    endtask

    task automatic wait_done(input bit noise);
        bit got;
        got = 1'b0;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (bus.done) begin
                got = 1'b1;
                break;
            end
            if (noise) begin
                bus.start = 1'($urandom_range(0, 1));
                bus.C     = 8'($urandom);
                bus.d     = 8'($urandom);
                bus.N     = 8'($urandom);
            end
        end
        bus.start = 1'b0;
        check("done_timeout", int'(got), 1);
    endtask

    task automatic run(input int c, input int dd, input int n, input bit noise);
        launch(c, dd, n);
        wait_done(noise);
    endtask

    // Monitor: pops the scoreboard on every done pulse
    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            if (prev_done) check("done_pulse_width", int'(bus.done), 0);
            if (bus.done) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check("M", int'(bus.M), e.m);
                    check("err", int'(bus.err), e.err);
                    check("latency", cyc - e.start_cyc, e.lat);
                    check("busy_during_run", busy_bad, 0);
                    check("busy_at_done", int'(bus.busy), 0);
                end
                busy_bad = 0;
            end else if (sb.size() != 0 && cyc >= sb[0].start_cyc && !bus.busy) begin
                busy_bad = 1;
            end
            prev_done = bus.done;
        end
    end

    initial begin
        int n, c, dd;
        n_vec = 0; n_err = 0; busy_bad = 0; prev_done = 1'b0; cyc = 0;
        reset = 1'b1;
        bus.start = 1'b0; bus.C = 8'd0; bus.d = 8'd0; bus.N = 8'd0;
        repeat (3) @(negedge clk);
        check("reset_M", int'(bus.M), 0);
        check("reset_busy", int'(bus.busy), 0);
        check("reset_done", int'(bus.done), 0);
        check("reset_err", int'(bus.err), 0);
        reset = 1'b0;

        run(31, 7, 33, 1'b0);
        run(8, 7, 33, 1'b0);
        run(47, 103, 143, 1'b0);
        run(20, 0, 33, 1'b0);
        run(20, 1, 33, 1'b0);
        run(0, 5, 33, 1'b0);
        run(0, 9, 1, 1'b0);
        run(40, 7, 33, 1'b0);
        run(5, 3, 0, 1'b0);
        run(31, 7, 33, 1'b0);

        // Reset in the middle of a run: outputs clear without waiting for a clock edge
        launch(47, 103, 143);
        repeat (60) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("midrun_reset_M", int'(bus.M), 0);
        check("midrun_reset_busy", int'(bus.busy), 0);
        check("midrun_reset_done", int'(bus.done), 0);
        check("midrun_reset_err", int'(bus.err), 0);
        sb.delete();
        busy_bad  = 0;
        prev_done = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        run(47, 103, 143, 1'b0);

        // Inputs and start toggled while busy must not disturb the accepted run
        run(31, 7, 33, 1'b1);
        run(47, 103, 143, 1'b1);

        for (int k = 0; k < 14; k++) begin
            n  = $urandom_range(2, 255);
            c  = $urandom_range(0, n - 1);
            dd = $urandom_range(0, 255);
            if (k % 5 == 4) c = n + $urandom_range(0, 255 - n);
            if (k % 7 == 6) n = $urandom_range(0, 1);
            run(c, dd, n, k % 3 == 0);
        end

        repeat (5) @(negedge clk);
        check("scoreboard_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/rsa_decrypt_core.md
Name: rsa_decrypt_core

Overview:
- Decryption end of the 4-bit RSA datapath: computes M = C^d mod N from the modulus and private exponent produced by key generation.
- Sequential left-to-right square-and-multiply; each modular product is done by an iterative shift-add mod-N multiplier.
- Fixed, data-independent latency (multiply always performed, result conditionally kept).
- Sits beside the encoder ALU and consumes its N output plus a stored d.

Parameters:
- W, 8, operand width of C, d, N, M (N from two 4-bit primes fits in 8 bits).

Ports:
- clk    input   1  rising-edge clock
- reset  input   1  asynchronous, active-high reset
- start  input   1  begin decryption; sampled only in IDLE
- C      input   W  ciphertext; must satisfy C < N
- d      input   W  private exponent
- N      input   W  modulus; must satisfy N >= 2
- M      output  W  plaintext; valid while done=1, held until the next start
- busy   output  1  high from the cycle after start is accepted until done
- done   output  1  one-cycle pulse when M/err are final
- err    output  1  set with done when inputs are illegal; held until the next start

Behaviour:
- Reset (async, any state): FSM to IDLE; M=0, busy=0, done=0, err=0; internal result, counters and multiplier cleared.
- Inputs C, d, N are latched on the start edge. Later input changes are ignored until the next start.
- start while busy is ignored; no queuing.
- FSM states: IDLE, CHECK, SQR, MUL, FIN.
  - IDLE: on start=1, latch inputs, clear err, go to CHECK.
  - CHECK (1 cycle):
    - If N<2 or C>=N: err=1, M=0, go to FIN.
    - Else result=1, bit index i=W-1, go to SQR.
  - SQR: issue result*result mod N; wait for the multiplier's done; store t=product; go to MUL.
  - MUL: issue t*C mod N; on multiplier done:
    - result = d[i] ? product : t.
    - If i==0 go to FIN, else i=i-1 and go to SQR.
  - FIN (1 cycle): done=1, busy=0, M=result (or 0 on err); return to IDLE.
- Modular multiplier (interleaved):
  - Operands A, B < N; 9-bit accumulator acc=0.
  - One iteration per cycle over B bits MSB to LSB:
    - t = 2*acc; if t>=N then t=t-N.
    - u = t + (B[j] ? A : 0); if u>=N then u=u-N.
    - acc = u.
  - Start cycle plus W iteration cycles = W+1 cycles per product.
  - Intermediates never exceed 2N-1 (9 bits).
- Latency from the start-sampling edge to the done cycle:
  - Legal inputs: 2 + 2*W*(W+1) cycles (146 for W=8).
  - Illegal inputs: 2 cycles.
- Edge cases:
  - d=0 gives M=1.
  - d=1 gives M=C.
  - C=0 gives M=0 for d>0.
- start asserted in the FIN cycle is ignored; it is accepted from IDLE on the next cycle.

Decomposition:
- Shared package (rsa_pkg):
  - Width constant W=8.
  - State encoding constants ST_IDLE, ST_CHECK, ST_SQR, ST_MUL, ST_FIN.
  - Derived latency constant LAT = 2+2*W*(W+1).
- Sub-module mod_mul_seq:
  - Ports: clk, reset, start, A, B, N, P, done.
  - Instantiated once and shared between SQR and MUL.
  - done is a one-cycle pulse W cycles after start.

Test Plan:
- N=33, d=7, C=31, start → M=4, err=0, done exactly 146 cycles after the start edge, busy high throughout.
- N=33, d=7, C=8 → M=2; then N=143, d=103, C=47 → M=5 (back-to-back runs, start held off until done).
- N=33, C=20, d=0 → M=1; d=1 → M=20; C=0, d=5 → M=0; all with 146-cycle latency.
- Illegal: N=1, C=0 → err=1, M=0, done 2 cycles after start; N=33, C=40 → err=1; the next legal run clears err.
- Assert reset at cycle 60 of a run → all outputs 0 immediately (async); a new start runs to a correct M with full latency.
- Pulse start repeatedly while busy, and change C/d/N mid-run → ignored; result matches the inputs latched at the accepted start.
